// File: rtl/gray_pkg.sv
// Shared gray-code helpers and command encoding for the gray encoder/decoder family.
// Functions work on 32-bit vectors; narrower values are zero-extended by the caller.
package gray_pkg;

   localparam int MAX_SIZE = 32;

   typedef enum logic [1:0] {
      CMD_HOLD,
      CMD_LOAD,
      CMD_INC,
      CMD_DEC
   } cmd_e;

   // All-ones value for a counter of the given width (2..32).
   function automatic logic [MAX_SIZE-1:0] max_of(input int size);
      logic [MAX_SIZE:0] full;
      full = ({{MAX_SIZE{1'b0}}, 1'b1} << size) - {{MAX_SIZE{1'b0}}, 1'b1};
      return full[MAX_SIZE-1:0];
   endfunction

   function automatic logic [MAX_SIZE-1:0] bin2gray(input logic [MAX_SIZE-1:0] b);
      logic [MAX_SIZE-1:0] g;
      for (int i = 0; i < MAX_SIZE - 1; i++) begin
         g[i] = b[i] ^ b[i+1];
      end
      g[MAX_SIZE-1] = b[MAX_SIZE-1];
      return g;
   endfunction

   function automatic logic [MAX_SIZE-1:0] gray2bin(input logic [MAX_SIZE-1:0] g);
      logic [MAX_SIZE-1:0] b;
      b[MAX_SIZE-1] = g[MAX_SIZE-1];
      for (int i = MAX_SIZE - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-gray encoder, one xor per bit.
module bin2gray_enc #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] bin,
   output logic [SIZE-1:0] gray
);

   for (genvar i = 0; i < SIZE - 1; i++) begin : g_bit
      assign gray[i] = bin[i] ^ bin[i+1];
   end
   assign gray[SIZE-1] = bin[SIZE-1];

endmodule

// File: rtl/gray_enc_counter.sv
// Up/down/load counter presenting its count registered in binary and gray code.
// Gray is encoded from the next-state value so the registered output never glitches.
module gray_enc_counter
   import gray_pkg::*;
#(
   parameter int          SIZE      = 8,
   parameter bit          WRAP      = 1'b1,
   parameter int unsigned RESET_BIN = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            dec,
   input  logic            load,
   input  logic [SIZE-1:0] load_bin,
   output logic [SIZE-1:0] bin,
   output logic [SIZE-1:0] gray,
   output logic            wrap,
   output logic            at_max,
   output logic            at_min
);

   localparam logic [MAX_SIZE-1:0] MAX_W       = max_of(SIZE);
   localparam logic [MAX_SIZE-1:0] RST_W       = RESET_BIN;
   localparam logic [MAX_SIZE-1:0] RST_GRAY_W  = bin2gray(RST_W);
   localparam logic [SIZE-1:0]     MAX_BIN     = MAX_W[SIZE-1:0];
   localparam logic [SIZE-1:0]     RST_BIN     = RST_W[SIZE-1:0];
   localparam logic [SIZE-1:0]     RST_GRAY    = RST_GRAY_W[SIZE-1:0];
   localparam logic [SIZE:0]       ONE_EXT     = {{SIZE{1'b0}}, 1'b1};

   cmd_e            cmd;
   logic [SIZE:0]   sum_ext;
   logic [SIZE:0]   diff_ext;
   logic [SIZE-1:0] bin_next;
   logic [SIZE-1:0] gray_next;
   logic            wrap_next;

   // Simultaneous inc and dec cancel out and are treated as hold.
   always_comb begin
      cmd = CMD_HOLD;
      if (load) begin
         cmd = CMD_LOAD;
      end else if (inc && !dec) begin
         cmd = CMD_INC;
      end else if (dec && !inc) begin
         cmd = CMD_DEC;
      end
   end

   assign sum_ext  = {1'b0, bin} + ONE_EXT;
   assign diff_ext = {1'b0, bin} - ONE_EXT;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      bin_next  = bin;
      wrap_next = 1'b0;
      unique case (cmd)
         CMD_LOAD: bin_next = load_bin;
         CMD_INC: begin
            wrap_next = sum_ext[SIZE];
            if (!sum_ext[SIZE] || WRAP) bin_next = sum_ext[SIZE-1:0];
         end
         CMD_DEC: begin
            wrap_next = diff_ext[SIZE];
            if (!diff_ext[SIZE] || WRAP) bin_next = diff_ext[SIZE-1:0];
         end
         default: bin_next = bin;
      endcase
   end

   bin2gray_enc #(.SIZE(SIZE)) u_enc (
      .bin  (bin_next),
      .gray (gray_next)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin    <= RST_BIN;
         gray   <= RST_GRAY;
         wrap   <= 1'b0;
         at_max <= (RST_BIN == MAX_BIN);
         at_min <= (RST_BIN == '0);
      end else begin
         bin    <= bin_next;
         gray   <= gray_next;
         wrap   <= wrap_next;
         at_max <= (bin_next == MAX_BIN);
         at_min <= (bin_next == '0);
      end
   end

endmodule

// File: tb/tb_gray_enc_counter.sv
// Directed and random bench for gray_enc_counter at SIZE=4, one wrapping and one saturating instance.
module tb_gray_enc_counter;
   import gray_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       inc = 1'b0;
   logic       dec = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_bin = 4'h0;

   logic [3:0] bin_w, gray_w, bin_s, gray_s;
   logic       wrap_w, max_w, min_w, wrap_s, max_s, min_s;

   int checks = 0;
   int errors = 0;

   // Reference model state for both instances.
   logic [3:0] m_w = 4'h5;
   logic [3:0] m_s = 4'h5;
   logic       mw_wrap = 1'b0;
   logic       ms_wrap = 1'b0;

   logic [3:0] seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

   always #5 clk = ~clk;

   gray_enc_counter #(.SIZE(4), .WRAP(1'b1), .RESET_BIN(5)) dut_w (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_bin(load_bin),
      .bin(bin_w), .gray(gray_w), .wrap(wrap_w), .at_max(max_w), .at_min(min_w)
   );

   gray_enc_counter #(.SIZE(4), .WRAP(1'b0), .RESET_BIN(5)) dut_s (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_bin(load_bin),
      .bin(bin_s), .gray(gray_s), .wrap(wrap_s), .at_max(max_s), .at_min(min_s)
   );

   // Expected {bin, gray, wrap, at_max, at_min}.
   function automatic logic [10:0] pack(input logic [3:0] b, input logic w);
      return {b, b ^ (b >> 1), w, b == 4'hF, b == 4'h0};
   endfunction

   task automatic model_next(inout logic [3:0] m, output logic w, input bit wrap_mode,
                             input logic i, input logic d, input logic l, input logic [3:0] lb);
      w = 1'b0;
      if (l) begin
         m = lb;
      end else if (i && !d) begin
         if (m == 4'hF) begin
            w = 1'b1;
            if (wrap_mode) m = 4'h0;
         end else begin
            m = m + 4'h1;
         end
      end else if (d && !i) begin
         if (m == 4'h0) begin
            w = 1'b1;
            if (wrap_mode) m = 4'hF;
         end else begin
            m = m - 4'h1;
         end
      end
   endtask

   task automatic step(input logic i, input logic d, input logic l, input logic [3:0] lb);
      inc = i; dec = d; load = l; load_bin = lb;
      @(posedge clk);
      #1;
      model_next(m_w, mw_wrap, 1'b1, i, d, l, lb);
      model_next(m_s, ms_wrap, 1'b0, i, d, l, lb);
      inc = 1'b0; dec = 1'b0; load = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bin_w, gray_w, wrap_w, max_w, min_w} !== {4'h5, 4'h7, 3'b000}) begin
         errors++;
         $display("FAIL reset_w: got %h required %h", {bin_w, gray_w, wrap_w, max_w, min_w}, {4'h5, 4'h7, 3'b000});
      end
      checks++;
      if ({bin_s, gray_s, wrap_s, max_s, min_s} !== {4'h5, 4'h7, 3'b000}) begin
         errors++;
         $display("FAIL reset_s: got %h required %h", {bin_s, gray_s, wrap_s, max_s, min_s}, {4'h5, 4'h7, 3'b000});
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_w = 4'h5; m_s = 4'h5; mw_wrap = 1'b0; ms_wrap = 1'b0;
   endtask

   task automatic test_up_count();
      logic [3:0]  prev;
      logic [31:0] dec_bin;
      step(1'b0, 1'b0, 1'b1, 4'h0);
      checks++;
      if ({bin_w, gray_w, wrap_w, max_w, min_w} !== {4'h0, 4'h0, 3'b001}) begin
         errors++;
         $display("FAIL load0_w: got %h required %h", {bin_w, gray_w, wrap_w, max_w, min_w}, {4'h0, 4'h0, 3'b001});
      end
      for (int k = 1; k <= 16; k++) begin
         prev = gray_w;
         step(1'b1, 1'b0, 1'b0, 4'h0);
         checks++;
         if (gray_w !== seq[k] || wrap_w !== (k == 16)) begin
            errors++;
            $display("FAIL up_seq[%0d]: got gray=%h wrap=%b required gray=%h wrap=%b", k, gray_w, wrap_w, seq[k], k == 16);
         end
         checks++;
         if ($countones(gray_w ^ prev) != 1) begin
            errors++;
            $display("FAIL up_onebit[%0d]: got %h->%h required one bit change", k, prev, gray_w);
         end
         dec_bin = gray2bin({28'h0, gray_w});
         checks++;
         if (dec_bin[3:0] !== bin_w) begin
            errors++;
            $display("FAIL up_decode[%0d]: got %h required %h", k, dec_bin[3:0], bin_w);
         end
         checks++;
         if ({bin_s, gray_s, wrap_s, max_s, min_s} !== pack(m_s, ms_wrap)) begin
            errors++;
            $display("FAIL up_sat[%0d]: got %h required %h", k, {bin_s, gray_s, wrap_s, max_s, min_s}, pack(m_s, ms_wrap));
         end
      end
      // Saturating instance was blocked at F on the last step.
      checks++;
      if ({bin_s, wrap_s, max_s} !== {4'hF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL up_sat_end: got bin=%h wrap=%b max=%b required bin=f wrap=1 max=1", bin_s, wrap_s, max_s);
      end
   endtask

   task automatic test_down_wrap();
      step(1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      checks++;
      if ({bin_w, gray_w, wrap_w, max_w, min_w} !== {4'hF, 4'h8, 3'b110}) begin
         errors++;
         $display("FAIL down_wrap_w: got %h required %h", {bin_w, gray_w, wrap_w, max_w, min_w}, {4'hF, 4'h8, 3'b110});
      end
      checks++;
      if ({bin_s, gray_s, wrap_s, max_s, min_s} !== {4'h0, 4'h0, 3'b101}) begin
         errors++;
         $display("FAIL down_sat_s: got %h required %h", {bin_s, gray_s, wrap_s, max_s, min_s}, {4'h0, 4'h0, 3'b101});
      end
      step(1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (wrap_w !== 1'b0 || wrap_s !== 1'b0 || bin_w !== 4'hF || bin_s !== 4'h0) begin
         errors++;
         $display("FAIL down_idle: got wrap_w=%b wrap_s=%b bin_w=%h bin_s=%h required 0 0 f 0", wrap_w, wrap_s, bin_w, bin_s);
      end
   endtask

   task automatic test_priority();
      step(1'b0, 1'b0, 1'b1, 4'h3);
      step(1'b1, 1'b1, 1'b1, 4'hA);
      checks++;
      if ({bin_w, gray_w, wrap_w} !== {4'hA, 4'hF, 1'b0} || {bin_s, gray_s, wrap_s} !== {4'hA, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL prio_load: got w=%h/%h/%b s=%h/%h/%b required a/f/0", bin_w, gray_w, wrap_w, bin_s, gray_s, wrap_s);
      end
      step(1'b1, 1'b1, 1'b0, 4'h0);
      checks++;
      if ({bin_w, gray_w, wrap_w} !== {4'hA, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL prio_hold: got %h/%h/%b required a/f/0", bin_w, gray_w, wrap_w);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b0, 1'b0, 1'b1, 4'hF);
      step(1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if ({bin_w, wrap_w, bin_s, wrap_s} !== {4'h0, 1'b1, 4'hF, 1'b1}) begin
         errors++;
         $display("FAIL b2b_1: got w=%h/%b s=%h/%b required 0/1 f/1", bin_w, wrap_w, bin_s, wrap_s);
      end
      step(1'b0, 1'b1, 1'b0, 4'h0);
      checks++;
      if ({bin_w, wrap_w, bin_s, wrap_s} !== {4'hF, 1'b1, 4'hE, 1'b0}) begin
         errors++;
         $display("FAIL b2b_2: got w=%h/%b s=%h/%b required f/1 e/0", bin_w, wrap_w, bin_s, wrap_s);
      end
   endtask

   task automatic test_mid_reset();
      step(1'b0, 1'b0, 1'b1, 4'h8);
      step(1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if (bin_w !== 4'h9 || gray_w !== 4'hD) begin
         errors++;
         $display("FAIL mid_pre: got %h/%h required 9/d", bin_w, gray_w);
      end
      inc = 1'b1; load = 1'b1; load_bin = 4'hC;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bin_w, gray_w, wrap_w, max_w, min_w} !== {4'h5, 4'h7, 3'b000}) begin
         errors++;
         $display("FAIL mid_reset: got %h required %h", {bin_w, gray_w, wrap_w, max_w, min_w}, {4'h5, 4'h7, 3'b000});
      end
      #1 rst_n = 1'b1;
      m_w = 4'h5; m_s = 4'h5; mw_wrap = 1'b0; ms_wrap = 1'b0;
      step(1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if ({bin_w, gray_w} !== {4'h6, 4'h5} || bin_s !== 4'h6) begin
         errors++;
         $display("FAIL mid_resume: got w=%h/%h s=%h required 6/5 6", bin_w, gray_w, bin_s);
      end
   endtask

   task automatic test_soak();
      logic [3:0] prev_w, prev_s, old_ms;
      logic       i, d, l;
      for (int n = 0; n < 10000; n++) begin
         prev_w = gray_w;
         prev_s = gray_s;
         old_ms = m_s;
         i = 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 7) == 0);
         step(i, d, l, 4'($urandom_range(0, 15)));
         checks++;
         if ({bin_w, gray_w, wrap_w, max_w, min_w} !== pack(m_w, mw_wrap)) begin
            errors++;
            $display("FAIL soak_w[%0d]: got %h required %h", n, {bin_w, gray_w, wrap_w, max_w, min_w}, pack(m_w, mw_wrap));
         end
         checks++;
         if ({bin_s, gray_s, wrap_s, max_s, min_s} !== pack(m_s, ms_wrap)) begin
            errors++;
            $display("FAIL soak_s[%0d]: got %h required %h", n, {bin_s, gray_s, wrap_s, max_s, min_s}, pack(m_s, ms_wrap));
         end
         if (!l && (i ^ d)) begin
            checks++;
            if ($countones(gray_w ^ prev_w) != 1 ||
                $countones(gray_s ^ prev_s) != ((old_ms != m_s) ? 1 : 0)) begin
               errors++;
               $display("FAIL soak_onebit[%0d]: got w %h->%h s %h->%h", n, prev_w, gray_w, prev_s, gray_s);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_wrap();
      test_priority();
      test_back_to_back();
      test_mid_reset();
      test_soak();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_enc_counter.md
Name: gray_enc_counter

Overview:
- Sequential binary-to-gray encoder/counter: the encoder-side counterpart of the team's gray-to-binary converters (gray2bin1/gray2bin2).
- Holds a SIZE-bit binary count and presents it registered, in both binary and gray code.
- The gray output changes by exactly one bit per count step, so it is safe to pass across clock domains to a gray2bin decoder (FIFO pointers, position counters).
- Supports increment, decrement, synchronous load, and wrap or saturate at the ends.

Parameters:
- SIZE, 8: counter width in bits; legal range 2..32.
- WRAP, 1: 1 = wrap modulo 2^SIZE; 0 = saturate at 0 and 2^SIZE-1.
- RESET_BIN, 0: binary reset value; must fit in SIZE bits.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset.
- inc  input  1  count up by one this cycle.
- dec  input  1  count down by one this cycle.
- load  input  1  synchronous load of load_bin.
- load_bin  input  SIZE  binary value to load.
- bin  output  SIZE  registered binary count.
- gray  output  SIZE  registered gray code of bin.
- wrap  output  1  one-cycle pulse: a wrap occurred (WRAP=1) or a saturating request was blocked (WRAP=0).
- at_max  output  1  registered flag, bin == 2^SIZE-1.
- at_min  output  1  registered flag, bin == 0.

Interface decision (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - bin = RESET_BIN, gray = RESET_BIN ^ (RESET_BIN >> 1), wrap = 0.
  - at_max and at_min take the values consistent with RESET_BIN.
  - Release is synchronous to clk; the first update happens on the first rising edge with rst_n high.
- Encoding: gray[i] = bin[i] ^ bin[i+1] for i < SIZE-1; gray[SIZE-1] = bin[SIZE-1].
- Registering: gray is computed from the next binary value and registered on the same edge as bin. It is never decoded combinationally from bin_q, so the output is glitch-free.
- Latency: one cycle. A command sampled at edge N appears on bin, gray and the flags after edge N.
- Command priority per cycle:
  1. load: next = load_bin; wrap = 0; inc and dec ignored.
  2. inc and dec both high: hold; wrap = 0.
  3. inc only: next = bin + 1.
  4. dec only: next = bin - 1.
  5. none: hold; wrap = 0.
- Boundaries with WRAP=1:
  - inc at 2^SIZE-1: next = 0, wrap = 1.
  - dec at 0: next = 2^SIZE-1, wrap = 1.
- Boundaries with WRAP=0:
  - inc at max or dec at 0: hold, wrap = 1 (overflow/underflow indication).
- Arithmetic is SIZE bits unsigned. The carry/borrow out of bit SIZE-1 is the wrap detect; it is never retained in bin.
- Single-bit property: any inc or dec step (including a wrap step) changes gray in exactly one bit. A load may change any number of bits.
- wrap is registered and high for exactly one cycle per event. Back-to-back wrap events (e.g. dec, dec at SIZE=1 equivalent, or repeated blocked requests) give wrap high on consecutive cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately; a pending load is lost.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(width-generic, generate-loop style over genvar i).
  - function gray2bin, for benches.
  - localparam helpers for MAX = 2^SIZE-1.
- One natural combinational sub-module: bin2gray_enc (SIZE parameter, per-bit xor generate loop). Instantiated once on the next-state value.
- The counter, priority logic and flag registers stay in gray_enc_counter.

Test Plan (SIZE=4):
- Reset: RESET_BIN=5, assert rst_n=0 without clock -> bin=4'h5, gray=4'h7, wrap=0, at_min=0, at_max=0 immediately.
- Full up-count, WRAP=1: from 0, inc held 16 cycles -> gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; exactly one gray bit flips per step; wrap=1 only on the F->0 step; gray2bin(gray)==bin every cycle.
- Down wrap and saturation: bin=0, dec -> bin=F, gray=8, wrap=1. Repeat with WRAP=0 -> bin stays 0, gray=0, wrap=1 for that single cycle, at_min=1.
- Priority: bin=3 with load=1, load_bin=A, inc=1, dec=1 -> bin=A, gray=F, wrap=0. Next cycle inc=dec=1 -> hold at A.
- Mid-operation reset: while incrementing at bin=9, pulse rst_n low between edges -> outputs return to reset values asynchronously. After release, counting resumes from RESET_BIN on the first edge.
- Random soak: 10k cycles of random inc/dec/load -> bin matches a reference model; single-bit gray change on every non-load step; wrap matches the model.
